// File: rtl/imagem_pkg.sv
// imagem_pkg: shared scan state encoding, default RAM depth and address wrap helper.
package imagem_pkg;
  localparam int MEM_WORDS_DEFAULT = 14848;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} scan_state_t;
  function automatic logic [13:0] wrap_inc(input logic [13:0] a, input int words);
    return (int'(a) == words - 1) ? 14'd0 : a + 14'd1;
  endfunction
endpackage

// File: rtl/imagem_pix_fifo.sv
// imagem_pix_fifo: synchronous pixel FIFO with occupancy count; push on full is accepted when a pop frees a slot.
module imagem_pix_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 32,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          empty,
  output logic [CW-1:0] count
);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_count;
  logic w_pop, w_push;
  assign w_pop  = pop & (r_count != '0);
  assign w_push = push & ((r_count != CW'(DEPTH)) | w_pop);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= din;
  assign empty = r_count == '0;
  assign dout  = empty ? '0 : r_mem[r_rd];
  assign count = r_count;
endmodule

// File: rtl/imagem_ram_arbiter.sv
// imagem_ram_arbiter: round-robin sharing of a single-port image RAM between a CPU slave
// and a credit-limited scanner that streams words into a pixel FIFO.
module imagem_ram_arbiter import imagem_pkg::*; #(
  parameter int MEM_WORDS  = MEM_WORDS_DEFAULT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] cpu_address,
  input  logic        cpu_chipselect,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [3:0]  cpu_byteenable,
  input  logic [31:0] cpu_writedata,
  output logic [31:0] cpu_readdata,
  output logic        cpu_readdatavalid,
  output logic        cpu_waitrequest,
  input  logic        scan_start,
  input  logic [13:0] scan_base,
  input  logic [13:0] scan_len,
  output logic        scan_busy,
  output logic        scan_done,
  output logic [31:0] pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [13:0] ram_address,
  output logic        ram_chipselect,
  output logic        ram_write,
  output logic [3:0]  ram_byteenable,
  output logic [31:0] ram_writedata,
  input  logic [31:0] ram_readdata
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  scan_state_t r_state;
  logic [13:0] r_addr, r_len, r_issued;
  logic r_last_cpu, r_scan_pend, r_cpu_pend, r_cpu_oor, r_done;
  logic [CW-1:0] w_count;
  logic w_empty, w_cpu_req, w_in_range, w_scan_req, w_gnt_cpu, w_gnt_scan;
  assign w_cpu_req  = cpu_chipselect & (cpu_read | cpu_write);
  assign w_in_range = int'(cpu_address) < MEM_WORDS;
  // Credit counts the word still on the RAM bus so the FIFO can never overflow.
  assign w_scan_req = (r_state == S_RUN) && (r_issued < r_len) &&
                      (int'(w_count) + int'(r_scan_pend) < FIFO_DEPTH);
  assign w_gnt_cpu  = !reset && w_cpu_req && (!w_scan_req || !r_last_cpu);
  assign w_gnt_scan = !reset && w_scan_req && !w_gnt_cpu;
  assign cpu_waitrequest   = w_cpu_req & !w_gnt_cpu;
  assign ram_chipselect    = (w_gnt_cpu & w_in_range) | w_gnt_scan;
  assign ram_write         = w_gnt_cpu & w_in_range & cpu_write;
  assign ram_address       = w_gnt_cpu ? cpu_address : w_gnt_scan ? r_addr : '0;
  assign ram_byteenable    = w_gnt_cpu ? cpu_byteenable : 4'hF;
  assign ram_writedata     = cpu_writedata;
  assign cpu_readdatavalid = r_cpu_pend;
  assign cpu_readdata      = (r_cpu_pend && !r_cpu_oor) ? ram_readdata : '0;
  assign scan_busy         = r_state != S_IDLE;
  assign scan_done         = r_done;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_len       <= '0;
      r_issued    <= '0;
      r_last_cpu  <= 1'b0;
      r_scan_pend <= 1'b0;
      r_cpu_pend  <= 1'b0;
      r_cpu_oor   <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_scan_pend <= w_gnt_scan;
      r_cpu_pend  <= w_gnt_cpu & !cpu_write;
      r_cpu_oor   <= !w_in_range;
      if (w_gnt_cpu | w_gnt_scan) r_last_cpu <= w_gnt_cpu;
      if (w_gnt_scan) begin
        r_addr   <= wrap_inc(r_addr, MEM_WORDS);
        r_issued <= r_issued + 14'd1;
      end
      case (r_state)
        S_IDLE: if (scan_start) begin
          r_addr   <= scan_base;
          r_len    <= scan_len;
          r_issued <= '0;
          r_state  <= (scan_len != '0) ? S_RUN : S_IDLE;
          r_done   <= scan_len == '0;
        end
        S_RUN: if (w_gnt_scan && (r_issued + 14'd1 == r_len)) r_state <= S_DRAIN;
        // The last read's data lands in the FIFO on this edge.
        S_DRAIN: if (r_scan_pend) begin
          r_state <= S_IDLE;
          r_done  <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  imagem_pix_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo (
    .clk(clk), .rst(reset), .push(r_scan_pend), .din(ram_readdata),
    .pop(pix_ready), .dout(pix_data), .empty(w_empty), .count(w_count)
  );
  assign pix_valid = !w_empty;
endmodule

// File: tb/tb_imagem_ram_arbiter.sv
// tb_imagem_ram_arbiter: CPU vector table, scan scoreboard and multi-cycle corner sequences
// against a behavioural single-port RAM with one-cycle read latency.
module tb_imagem_ram_arbiter;
  localparam int MW = 14848;
  localparam int FD = 4;
  logic clk = 1'b0, reset = 1'b1;
  logic [13:0] cpu_address = '0;
  logic cpu_chipselect = 1'b0, cpu_read = 1'b0, cpu_write = 1'b0;
  logic [3:0] cpu_byteenable = 4'hF;
  logic [31:0] cpu_writedata = '0;
  logic [31:0] cpu_readdata;
  logic cpu_readdatavalid, cpu_waitrequest;
  logic scan_start = 1'b0;
  logic [13:0] scan_base = '0, scan_len = '0;
  logic scan_busy, scan_done, pix_valid;
  logic [31:0] pix_data;
  logic pix_ready = 1'b1;
  logic [13:0] ram_address;
  logic ram_chipselect, ram_write;
  logic [3:0] ram_byteenable;
  logic [31:0] ram_writedata, ram_readdata;

  imagem_ram_arbiter #(.MEM_WORDS(MW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset),
    .cpu_address(cpu_address), .cpu_chipselect(cpu_chipselect), .cpu_read(cpu_read),
    .cpu_write(cpu_write), .cpu_byteenable(cpu_byteenable), .cpu_writedata(cpu_writedata),
    .cpu_readdata(cpu_readdata), .cpu_readdatavalid(cpu_readdatavalid),
    .cpu_waitrequest(cpu_waitrequest),
    .scan_start(scan_start), .scan_base(scan_base), .scan_len(scan_len),
    .scan_busy(scan_busy), .scan_done(scan_done),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .ram_address(ram_address), .ram_chipselect(ram_chipselect), .ram_write(ram_write),
    .ram_byteenable(ram_byteenable), .ram_writedata(ram_writedata), .ram_readdata(ram_readdata)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int i);
    return 32'h5A000000 ^ (32'(i) * 32'h00010003);
  endfunction

  logic [31:0] mem [16384];
  bit mem_init;
  always @(posedge clk)
    if (!mem_init) begin
      for (int i = 0; i < 16384; i++) mem[i] <= pat(i);
      mem_init <= 1'b1;
    end else if (ram_chipselect) begin
      if (ram_write) begin
        for (int b = 0; b < 4; b++)
          if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
      end else ram_readdata <= mem[ram_address];
    end

  logic [31:0] pix_q[$];
  logic [13:0] scan_addrs[$];
  int done_cnt = 0, oor_cnt = 0;
  always @(negedge clk) begin
    if (!reset && pix_valid && pix_ready) begin
      if (pix_q.size() == 0) chk("pix_unexpected", 32'd1, 32'd0);
      else chk("pix_data", pix_data, pix_q.pop_front());
    end
    if (!reset && ram_chipselect && !ram_write &&
        !(cpu_chipselect && (cpu_read || cpu_write) && !cpu_waitrequest))
      scan_addrs.push_back(ram_address);
    if (scan_done) done_cnt++;
    if (ram_chipselect && int'(ram_address) >= MW) oor_cnt++;
  end

  bit hold_mode;
  int wr_run, wr_max, rdv_cnt, rd_bad;
  always @(negedge clk)
    if (!hold_mode) begin
      wr_run = 0; wr_max = 0; rdv_cnt = 0; rd_bad = 0;
    end else begin
      if (cpu_chipselect && cpu_read && cpu_waitrequest) begin
        wr_run++;
        if (wr_run > wr_max) wr_max = wr_run;
      end else wr_run = 0;
      if (cpu_readdatavalid) begin
        rdv_cnt++;
        if (cpu_readdata !== 32'hA5A51234) rd_bad++;
      end
    end

  task automatic cpu_op(input bit wr, input logic [13:0] a, input logic [3:0] be,
                        input logic [31:0] d, output logic [31:0] rd, output logic rdv,
                        output int waits);
    @(posedge clk); #1;
    cpu_chipselect = 1'b1; cpu_read = !wr; cpu_write = wr;
    cpu_address = a; cpu_byteenable = be; cpu_writedata = d; waits = 0;
    @(negedge clk);
    while (cpu_waitrequest && waits < 50) begin waits++; @(negedge clk); end
    @(posedge clk); #1;
    cpu_chipselect = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0;
    @(negedge clk);
    rdv = cpu_readdatavalid; rd = cpu_readdata;
  endtask

  task automatic start_scan(input int base, input int len);
    for (int i = 0; i < len; i++) pix_q.push_back(mem[(base + i) % MW]);
    scan_addrs.delete();
    @(posedge clk); #1;
    scan_start = 1'b1; scan_base = 14'(base); scan_len = 14'(len);
    @(posedge clk); #1;
    scan_start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int n = 0;
    @(negedge clk);
    while (!scan_done && n < budget) begin n++; @(negedge clk); end
    chk({nm, "_done"}, 32'(scan_done), 32'd1);
    chk({nm, "_busy_at_done"}, 32'(scan_busy), 32'd0);
  endtask

  typedef struct {
    bit wr; logic [13:0] a; logic [3:0] be; logic [31:0] d; logic [31:0] exp;
  } vec_t;
  vec_t vecs[11];

  initial begin
    logic [31:0] rd;
    logic rdv;
    int waits, d0, pv;
    vecs[0]  = '{1'b1, 14'd5,     4'hF, 32'hA5A51234, 32'h0};
    vecs[1]  = '{1'b0, 14'd5,     4'hF, 32'h0,        32'hA5A51234};
    vecs[2]  = '{1'b1, 14'd6,     4'hF, 32'h11223344, 32'h0};
    vecs[3]  = '{1'b1, 14'd6,     4'h5, 32'hAABBCCDD, 32'h0};
    vecs[4]  = '{1'b0, 14'd6,     4'hF, 32'h0,        32'h11BB33DD};
    vecs[5]  = '{1'b1, 14'd14847, 4'hF, 32'hDEADBEEF, 32'h0};
    vecs[6]  = '{1'b0, 14'd14847, 4'hF, 32'h0,        32'hDEADBEEF};
    vecs[7]  = '{1'b1, 14'd14848, 4'hF, 32'h12345678, 32'h0};
    vecs[8]  = '{1'b0, 14'd14848, 4'hF, 32'h0,        32'h0};
    vecs[9]  = '{1'b0, 14'd16383, 4'hF, 32'h0,        32'h0};
    vecs[10] = '{1'b0, 14'd0,     4'hF, 32'h0,        pat(0)};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_flags", 32'({cpu_readdatavalid, scan_busy, scan_done, pix_valid,
                            ram_chipselect, ram_write, cpu_waitrequest}), 32'd0);
    chk("reset_cpu_readdata", cpu_readdata, 32'd0);
    chk("reset_pix_data", pix_data, 32'd0);
    chk("reset_ram_address", 32'(ram_address), 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      cpu_op(vecs[i].wr, vecs[i].a, vecs[i].be, vecs[i].d, rd, rdv, waits);
      chk($sformatf("cpu%0d_waits", i), 32'(waits), 32'd0);
      chk($sformatf("cpu%0d_rdv", i), 32'(rdv), 32'(!vecs[i].wr));
      if (!vecs[i].wr) chk($sformatf("cpu%0d_data", i), rd, vecs[i].exp);
    end
    chk("oor_strobe", 32'(oor_cnt), 32'd0);

    d0 = done_cnt;
    start_scan(10, 8);
    wait_done("scan8", 100);
    repeat (5) @(negedge clk);
    chk("scan8_done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("scan8_count", 32'(scan_addrs.size()), 32'd8);
    for (int i = 0; i < 8 && i < scan_addrs.size(); i++)
      chk($sformatf("scan8_addr%0d", i), 32'(scan_addrs[i]), 32'(10 + i));
    chk("scan8_drained", 32'(pix_q.size()), 32'd0);

    @(posedge clk); #1;
    cpu_chipselect = 1'b1; cpu_read = 1'b1; cpu_address = 14'd5;
    hold_mode = 1'b1;
    start_scan(10, 8);
    wait_done("cont", 100);
    @(posedge clk); #1;
    cpu_chipselect = 1'b0; cpu_read = 1'b0;
    @(negedge clk);
    chk("cont_max_wait", 32'(wr_max), 32'd1);
    chk("cont_rdv_enough", 32'(rdv_cnt >= 8), 32'd1);
    chk("cont_rd_data", 32'(rd_bad), 32'd0);
    hold_mode = 1'b0;
    chk("cont_count", 32'(scan_addrs.size()), 32'd8);
    for (int i = 0; i < 8 && i < scan_addrs.size(); i++)
      chk($sformatf("cont_addr%0d", i), 32'(scan_addrs[i]), 32'(10 + i));
    repeat (3) @(negedge clk);
    chk("cont_drained", 32'(pix_q.size()), 32'd0);

    pix_ready = 1'b0;
    start_scan(100, 16);
    repeat (20) @(negedge clk);
    chk("bp_reads_credit", 32'(scan_addrs.size()), 32'(FD));
    chk("bp_pix_valid", 32'(pix_valid), 32'd1);
    chk("bp_busy", 32'(scan_busy), 32'd1);
    @(posedge clk); #1 pix_ready = 1'b1;
    wait_done("bp", 200);
    repeat (5) @(negedge clk);
    chk("bp_reads_total", 32'(scan_addrs.size()), 32'd16);
    chk("bp_drained", 32'(pix_q.size()), 32'd0);

    start_scan(14846, 4);
    wait_done("wrap", 100);
    repeat (5) @(negedge clk);
    chk("wrap_count", 32'(scan_addrs.size()), 32'd4);
    if (scan_addrs.size() == 4) begin
      chk("wrap_a0", 32'(scan_addrs[0]), 32'd14846);
      chk("wrap_a1", 32'(scan_addrs[1]), 32'd14847);
      chk("wrap_a2", 32'(scan_addrs[2]), 32'd0);
      chk("wrap_a3", 32'(scan_addrs[3]), 32'd1);
    end
    chk("wrap_drained", 32'(pix_q.size()), 32'd0);

    d0 = done_cnt;
    start_scan(50, 0);
    wait_done("len0", 0);
    repeat (5) @(negedge clk);
    chk("len0_no_reads", 32'(scan_addrs.size()), 32'd0);
    chk("len0_done_pulses", 32'(done_cnt - d0), 32'd1);

    pix_ready = 1'b0;
    start_scan(200, 8);
    repeat (6) @(negedge clk);
    @(posedge clk); #1 reset = 1'b1;
    #1;
    chk("rst_mid_flags", 32'({cpu_readdatavalid, scan_busy, scan_done, pix_valid,
                              ram_chipselect, ram_write}), 32'd0);
    chk("rst_mid_pix_data", pix_data, 32'd0);
    chk("rst_mid_ram_address", 32'(ram_address), 32'd0);
    pix_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0; pix_ready = 1'b1;
    scan_addrs.delete();
    pv = 0;
    repeat (10) begin @(negedge clk); if (pix_valid) pv++; end
    chk("rst_mid_no_stale_pix", 32'(pv), 32'd0);
    chk("rst_mid_no_reads", 32'(scan_addrs.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
